neopixel_rx: RTL and testbench
==============================

NEOPIXEL_RX -- requirements
Module: neopixel_rx

Interface
REQ-001 Parameter BIT_THRESH, default 10: high-pulse length in clocks at or above which a bit decodes as 1.
REQ-002 Parameter MAX_HIGH, default 40: high-pulse length in clocks at or above which the pulse is a protocol error.
REQ-003 Parameter LATCH_CYCLES, default 800 (50 us at 16 MHz): low time in clocks that constitutes a latch/reset gap.
REQ-004 clk_16MHz  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  1  asynchronous WS2812-format serial line.
REQ-007 data_out  output  24  last completed word, first received bit in bit 23 (GRB order, MSB first).
REQ-008 data_valid  output  1  one-cycle pulse: data_out updated.
REQ-009 pixel_idx  output  16  index of the word in data_out within the current frame, 0-based.
REQ-010 frame_done  output  1  one-cycle pulse on latch gap after at least one edge.
REQ-011 err  output  1  one-cycle pulse on protocol error.
REQ-012 dout  output  1  forwarded line (see Configuration).

Function
REQ-013 din passes through a 2-flop synchronizer to din_s; all decoding uses din_s only.
REQ-014 State machine: SYNC, IDLE, HIGH, DISCARD.
REQ-015 SYNC: entered on reset. Moves to IDLE once din_s has stayed low for LATCH_CYCLES consecutive clocks. A high din_s restarts the count.
REQ-016 IDLE: a rising edge of din_s moves to HIGH with hi_cnt = 1. Otherwise lo_cnt increments, saturating at LATCH_CYCLES.
REQ-017 HIGH: hi_cnt increments while din_s = 1.
REQ-018 HIGH, falling edge, hi_cnt < 2: glitch, ignored; return to IDLE with no bit recorded.
REQ-019 HIGH, falling edge, 2 <= hi_cnt < BIT_THRESH: shift in 0, return to IDLE.
REQ-020 HIGH, falling edge, BIT_THRESH <= hi_cnt < MAX_HIGH: shift in 1, return to IDLE.
REQ-021 hi_cnt reaching MAX_HIGH: err pulses the next cycle, the partial word is discarded, and the FSM goes to DISCARD.
REQ-022 DISCARD: behaves as SYNC (waits for a LATCH_CYCLES low gap), then goes to IDLE without a frame_done pulse.
REQ-023 The 24th bit of a word loads data_out and pulses data_valid in the cycle after the falling edge is seen on din_s.
REQ-024 After each data_valid, the bit count clears. pixel_idx equals the word's frame index during the pulse and increments after it.
REQ-025 There is no backpressure; a consumer that ignores a data_valid pulse loses that word.
REQ-026 IDLE, lo_cnt reaching LATCH_CYCLES: frame_done pulses once, and pixel_idx and the bit count clear.
REQ-027 If the bit count is nonzero at the latch, err pulses in the same cycle as frame_done and the partial word is discarded.
REQ-028 A latch with no edges since the previous latch produces no pulse.
REQ-029 pixel_idx wraps from 65535 to 0 without error.

Reset
REQ-030 Asynchronous assertion of rst_n = 0 sets all of the following immediately: state SYNC, synchronizer flops 0, all counters 0, data_out 0, data_valid 0, frame_done 0, err 0, pixel_idx 0, dout 0.
REQ-031 Reset mid-word discards all partial state; decoding after release requires a full LATCH_CYCLES low gap.

Configuration
REQ-032 With NEOPIXEL_RX_FWD_EN defined, dout = din_s from the cycle after the frame's first data_valid (pixel_idx 0) until the next latch/frame_done or err. dout is 0 at all other times, emulating one consuming pixel in a chain.
REQ-033 Without NEOPIXEL_RX_FWD_EN, dout is tied to 0 and no forwarding logic is built.

Verification
REQ-034 After reset, 800 low clocks, then word 0xA5C3F0 (0-bit: 6 high/14 low, 1-bit: 13 high/7 low) -> one data_valid, data_out = 0xA5C3F0, pixel_idx = 0.
REQ-035 Two words 0x123456 and 0xFFFFFF, then 800 low clocks -> data_valid with pixel_idx 0, then with pixel_idx 1, then exactly one frame_done and no err.
REQ-036 12 bits, then 800 low clocks -> err and frame_done in the same cycle, no data_valid, pixel_idx = 0 afterward.
REQ-037 High pulse of 45 clocks mid-word -> err pulse, no data_valid until after an 800-clock low gap and a fresh word.
REQ-038 1-clock high glitches between bits of 0x000001 -> data_out = 0x000001, no err.
REQ-039 NEOPIXEL_RX_FWD_EN defined, three-word frame -> dout stays 0 during word 0, mirrors din delayed 2 clocks for words 1 and 2, and returns to 0 at frame_done. Separately: rst_n pulsed low mid-word -> outputs clear immediately.

Source files
------------

// File: rtl/neopixel_rx.sv
// WS2812 serial receiver: decodes high-pulse widths into 24-bit GRB words and frames.
// Define NEOPIXEL_RX_FWD_EN to forward the line on dout after the first word, like a chained pixel.
`timescale 1ns/1ps
module neopixel_rx #(
  parameter int BIT_THRESH   = 10,
  parameter int MAX_HIGH     = 40,
  parameter int LATCH_CYCLES = 800
) (
  input  logic        clk_16MHz,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic [15:0] pixel_idx,
  output logic        frame_done,
  output logic        err,
  output logic        dout
);
  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [HW-1:0] HI_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HI_ONE = HW'(BIT_THRESH);
  localparam logic [HW-1:0] HI_MIN = HW'(2);
  localparam logic [LW-1:0] LAT    = LW'(LATCH_CYCLES);
  localparam logic [LW-1:0] LAT_M1 = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, DISCARD} state_e;

  state_e          state_q, state_d;
  logic            din_meta_q, din_s_q;
  logic [HW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [LW-1:0]   lo_cnt_q, lo_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [22:0]     shift_q, shift_d;
  logic [23:0]     data_q, data_d;
  logic [15:0]     idx_q, idx_d;
  logic            dv_q, dv_d, fd_q, fd_d, err_q, err_d;
  logic            bit_v;

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
    end else begin
      din_meta_q <= din;
      din_s_q    <= din_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fd_d      = 1'b0;
    err_d     = 1'b0;
    bit_v     = 1'b0;
    idx_d     = dv_q ? idx_q + 16'd1 : idx_q;
    unique case (state_q)
      SYNC, DISCARD: begin
        // Any high restarts the gap count; no frame_done when the gap completes.
        if (din_s_q) begin
          lo_cnt_d = '0;
        end else if (lo_cnt_q == LAT_M1) begin
          lo_cnt_d = LAT;
          state_d  = IDLE;
        end else begin
          lo_cnt_d = lo_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (din_s_q) begin
          state_d  = HIGH;
          hi_cnt_d = HW'(1);
          lo_cnt_d = '0;
        end else if (lo_cnt_q != LAT) begin
          // lo_cnt saturates, so a gap with no edges since the last latch stays silent.
          lo_cnt_d = lo_cnt_q + 1'b1;
          if (lo_cnt_q == LAT_M1) begin
            fd_d      = 1'b1;
            err_d     = (bit_cnt_q != 5'd0);
            bit_cnt_d = '0;
            idx_d     = '0;
          end
        end
      end
      HIGH: begin
        if (din_s_q) begin
          hi_cnt_d = hi_cnt_q + 1'b1;
          if (hi_cnt_d == HI_MAX) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            idx_d     = '0;
            lo_cnt_d  = '0;
            state_d   = DISCARD;
          end
        end else begin
          state_d  = IDLE;
          lo_cnt_d = LW'(1);
          if (hi_cnt_q >= HI_MIN) begin
            bit_v = (hi_cnt_q >= HI_ONE);
            if (bit_cnt_q == 5'd23) begin
              data_d    = {shift_q, bit_v};
              dv_d      = 1'b1;
              bit_cnt_d = '0;
            end else begin
              shift_d   = {shift_q[21:0], bit_v};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      dv_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      dv_q      <= dv_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign pixel_idx  = idx_q;
  assign frame_done = fd_q;
  assign err        = err_q;

`ifdef NEOPIXEL_RX_FWD_EN
  logic fwd_q, fwd_d;

  // Word 0 is consumed here; everything after it in the frame passes downstream.
  always_comb begin
    fwd_d = fwd_q;
    if (dv_q && (idx_q == 16'd0)) fwd_d = 1'b1;
    if (fd_d || err_d)            fwd_d = 1'b0;
  end

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) fwd_q <= 1'b0;
    else        fwd_q <= fwd_d;
  end

  assign dout = fwd_q & din_s_q;
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx: words queued when driven, checked on data_valid; dout checked every cycle.
`timescale 1ns/1ps
module tb_neopixel_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [23:0] data_out;
  logic        data_valid;
  logic [15:0] pixel_idx;
  logic        frame_done;
  logic        err;
  logic        dout;

  always #5 clk = ~clk;

  neopixel_rx dut (
    .clk_16MHz (clk),
    .rst_n     (rst_n),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .pixel_idx (pixel_idx),
    .frame_done(frame_done),
    .err       (err),
    .dout      (dout)
  );

`ifdef NEOPIXEL_RX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int vectors = 0, miscompares = 0;
  int dv_cnt = 0, fd_cnt = 0, err_cnt = 0, fd_err_cnt = 0;
  logic [39:0] exp_q[$];
  bit   fwd_mode = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0;

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    drive(1'b1, b ? 13 : 6);
    drive(1'b0, b ? 7 : 14);
    if (glitch) begin
      drive(1'b1, 1);
      drive(1'b0, 5);
    end
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic send_word(input logic [23:0] w, input logic [15:0] idx, input bit glitch);
    exp_q.push_back({idx, w});
    for (int i = 23; i >= 0; i--) send_bit(w[i], glitch);
  endtask

  task automatic monitor();
    logic [39:0] e;
    logic        exp_dout;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fwd_mode = 1'b0;
      end else begin
        exp_dout = (FWD && fwd_mode && !frame_done && !err) ? d2 : 1'b0;
        vectors++;
        if (dout !== exp_dout) begin
          miscompares++;
          $display("FAIL dout: got %b want %b at %0t", dout, exp_dout, $time);
        end
        if (data_valid) begin
          dv_cnt++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL word: unexpected data_valid data %h idx %0d", data_out, pixel_idx);
          end else begin
            e = exp_q.pop_front();
            if ({pixel_idx, data_out} !== e)begin
              miscompares++;
              $display("FAIL word: got idx %0d data %h want idx %0d data %h",
                       pixel_idx, data_out, e[39:24], e[23:0]);
            end
          end
        end
        if (frame_done) fd_cnt++;
        if (err) err_cnt++;
        if (frame_done && err) fd_err_cnt++;
        if (frame_done || err) fwd_mode = 1'b0;
        if (data_valid && pixel_idx == 16'd0) fwd_mode = 1'b1;
      end
      d2 = d1;
      d1 = din;
    end
  endtask

  task automatic check_counts(input string name, input int dv0, input int fd0, input int er0,
                              input logic [23:0] want);
    logic [23:0] got;
    got = {8'(dv_cnt - dv0), 8'(fd_cnt - fd0), 8'(err_cnt - er0)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s counts dv/fd/err: got %0d/%0d/%0d want %0d/%0d/%0d", name,
               got[23:16], got[15:8], got[7:0], want[23:16], want[15:8], want[7:0]);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: got %0d words pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({data_out, data_valid, pixel_idx, frame_done, err, dout} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h want 0",
               {data_out, data_valid, pixel_idx, frame_done, err, dout});
    end
    #1 rst_n = 1'b1;
    drive(1'b0, 810);
  endtask

  task automatic test_single_word();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_word(24'hA5C3F0, 16'd0, 1'b0);
    check_counts("single_word", dv0, fd0, er0, {8'd1, 8'd0, 8'd0});
    drive(1'b0, 820);
    check_counts("single_latch", dv0, fd0, er0, {8'd1, 8'd1, 8'd0});
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_word(24'h123456, 16'd0, 1'b0);
    send_word(24'hFFFFFF, 16'd1, 1'b0);
    drive(1'b0, 820);
    check_counts("back_to_back", dv0, fd0, er0, {8'd2, 8'd1, 8'd0});
    vectors++;
    if (pixel_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b pixel_idx: got %0d want 0", pixel_idx);
    end
  endtask

  task automatic test_partial();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt, fe0 = fd_err_cnt;
    send_bits(24'hABC000, 12);
    drive(1'b0, 820);
    check_counts("partial", dv0, fd0, er0, {8'd0, 8'd1, 8'd1});
    vectors++;
    if (fd_err_cnt - fe0 !== 1) begin
      miscompares++;
      $display("FAIL partial same_cycle: got %0d want 1", fd_err_cnt - fe0);
    end
    vectors++;
    if (pixel_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL partial pixel_idx: got %0d want 0", pixel_idx);
    end
  endtask

  task automatic test_long_high();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_bits(24'h00005A, 8);
    drive(1'b1, 45);
    drive(1'b0, 810);
    check_counts("long_high", dv0, fd0, er0, {8'd0, 8'd0, 8'd1});
    send_word(24'h00FF00, 16'd0, 1'b0);
    drive(1'b0, 820);
    check_counts("long_high_recover", dv0, fd0, er0, {8'd1, 8'd1, 8'd1});
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_word(24'h000001, 16'd0, 1'b1);
    drive(1'b0, 820);
    check_counts("glitch", dv0, fd0, er0, {8'd1, 8'd1, 8'd0});
  endtask

  task automatic test_forward();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_word(24'hF0F0F0, 16'd0, 1'b0);
    send_word(24'h0F0F0F, 16'd1, 1'b0);
    send_word(24'hAAAAAA, 16'd2, 1'b0);
    drive(1'b0, 820);
    check_counts("forward", dv0, fd0, er0, {8'd3, 8'd1, 8'd0});
  endtask

  task automatic test_midword_reset();
    int dv0 = dv_cnt, fd0 = fd_cnt, er0 = err_cnt;
    send_word(24'hABCDEF, 16'd0, 1'b0);
    send_bits(24'h3FF000, 10);
    din = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({data_out, data_valid, pixel_idx, frame_done, err, dout} !== 44'd0) begin
      miscompares++;
      $display("FAIL midword_reset outputs: got %h want 0",
               {data_out, data_valid, pixel_idx, frame_done, err, dout});
    end
    repeat (3) @(posedge clk);
    #1 din = 1'b0;
    rst_n = 1'b1;
    // No gap yet after reset, so this word must be ignored.
    send_bits(24'h777777, 24);
    check_counts("reset_no_gap", dv0, fd0, er0, {8'd1, 8'd0, 8'd0});
    drive(1'b0, 810);
    send_word(24'h5A5A5A, 16'd0, 1'b0);
    drive(1'b0, 820);
    check_counts("reset_recover", dv0, fd0, er0, {8'd2, 8'd1, 8'd0});
  endtask

  initial begin
    din   = 1'b0;
    rst_n = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial();
    test_long_high();
    test_glitch();
    test_forward();
    test_midword_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
